// File: rtl/fb_pixel_prefetch_pkg.sv
// Shared definitions for the framebuffer pixel prefetcher and the vga block.
// Contents: prefetch FSM state encoding, default frame size, pixel width.
package fb_pixel_prefetch_pkg;

  // Prefetch sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } pf_state_e;

  // 640x480, one framebuffer word per pixel
  localparam int unsigned FRAME_PIX_DEF = 307200;

  // Pixel width delivered to the vga data input
  localparam int unsigned PIX_W = 4;

endpackage

// File: rtl/fb_pixel_prefetch_sync_fifo.sv
// Synchronous FIFO holding prefetched pixels.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push/wr_data  write one entry (ignored when full or flushing)
//   pop           advance the read pointer (ignored when empty or flushing)
//   flush         empty the FIFO in one cycle
//   head_c        entry at the read pointer (combinational read)
//   count         number of stored entries
//   empty, full   occupancy flags decoded from count
module fb_pixel_prefetch_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_c,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head_c  = mem[rd_ptr];

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fb_pixel_prefetch.sv
// Framebuffer pixel prefetcher: reads framebuffer words ahead of the vga
// scan-out and delivers one 4-bit pixel per pixel strobe from a small FIFO,
// hiding the fixed memory read latency.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   frame_start   pulse at start of vertical blank; restarts prefetch at address 0
//   pix_en        pixel strobe
//   active        vga visible region
//   mem_addr      framebuffer read address
//   mem_rd        read request, one word per asserted cycle
//   mem_q         read data, valid RD_LAT cycles after mem_rd
//   pix_data      registered pixel for the vga data input
//   underflow     one-cycle pulse when a pixel is requested from an empty FIFO
//   underflow_cnt saturating underflow counter (only with UNDERFLOW_CNT_EN)
// Build option: define UNDERFLOW_CNT_EN to add underflow_cnt.
module fb_pixel_prefetch
  import fb_pixel_prefetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FRAME_PIX  = FRAME_PIX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_en,
  input  logic              active,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_q,
  output logic [PIX_W-1:0]  pix_data,
  output logic              underflow
`ifdef UNDERFLOW_CNT_EN
  ,
  output logic [15:0]       underflow_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

  pf_state_e         state;
  pf_state_e         state_nxt;
  logic              mem_rd_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;

  logic [RD_LAT-1:0] tag_sr;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [PIX_W-1:0]  fifo_head_c;

  logic [OCC_W-1:0]  occ_c;
  logic              issue_ok_c;
  logic              last_issue_c;
  logic              want_pix_c;
  logic              push_c;
  logic              pop_c;
  logic              underflow_nxt;
  logic              unused_q_hi;

  // Only the low nibble of each word is a pixel
  assign unused_q_hi = ^mem_q[DATA_W-1:PIX_W];

  // frame_start flushes everything, so it overrides push and pop
  assign want_pix_c    = pix_en && active && !frame_start;
  assign pop_c         = want_pix_c && !fifo_empty;
  assign underflow_nxt = want_pix_c && fifo_empty;
  assign push_c        = tag_sr[RD_LAT-1] && !frame_start && !fifo_full;

  // Projected occupancy: stored words + words in the latency pipe + the request on the bus now.
  // Pops are not credited, so the FIFO can never overflow.
  always_comb begin
    occ_c = OCC_W'(fifo_count) + OCC_W'(mem_rd);
    for (int i = 0; i < RD_LAT; i++) begin
      occ_c = occ_c + OCC_W'(tag_sr[i]);
    end
  end

  assign issue_ok_c   = (occ_c < OCC_W'(FIFO_DEPTH));
  assign last_issue_c = mem_rd && (mem_addr == ADDR_W'(FRAME_PIX - 1));

  // FSM next state and read request generation
  always_comb begin
    state_nxt    = state;
    mem_rd_nxt   = 1'b0;
    mem_addr_nxt = mem_rd ? mem_addr + ADDR_W'(1) : mem_addr;
    if (frame_start) begin
      // FIFO and pipe are flushed this edge, so the first request is always allowed
      state_nxt    = FILL;
      mem_rd_nxt   = 1'b1;
      mem_addr_nxt = '0;
    end else begin
      case (state)
        FILL, RUN: begin
          if (last_issue_c) begin
            state_nxt = DONE;
          end else begin
            mem_rd_nxt = issue_ok_c;
            if (state == FILL && fifo_count == CNT_W'(FIFO_DEPTH)) state_nxt = RUN;
          end
        end
        IDLE, DONE: ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM state and memory request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_nxt;
      mem_rd   <= mem_rd_nxt;
      mem_addr <= mem_addr_nxt;
    end
  end

  // Latency tags: a tag leaves the top bit on the cycle its word is on mem_q
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      tag_sr <= '0;
    end else begin
      tag_sr <= (tag_sr << 1) | RD_LAT'(mem_rd);
    end
  end

  // Pixel output register: holds outside the visible region
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_data  <= '0;
      underflow <= 1'b0;
    end else begin
      underflow <= underflow_nxt;
      if (pop_c) begin
        pix_data <= fifo_head_c;
      end else if (underflow_nxt) begin
        pix_data <= '0;
      end
    end
  end

`ifdef UNDERFLOW_CNT_EN
  // Saturating underflow counter, survives frame_start
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_cnt <= '0;
    end else if (underflow_nxt && underflow_cnt != 16'hFFFF) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end
`endif

  fb_pixel_prefetch_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .wr_data (mem_q[PIX_W-1:0]),
    .pop     (pop_c),
    .flush   (frame_start),
    .head_c  (fifo_head_c),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

endmodule

// File: tb/tb_fb_pixel_prefetch.sv
// Directed testbench for fb_pixel_prefetch with a 2-cycle-latency memory
// model returning q = addr[7:0]. A reduced frame size keeps the run short.
module tb_fb_pixel_prefetch;

  localparam int unsigned FP = 1200;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        pix_en;
  logic        active;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_q;
  logic [3:0]  pix_data;
  logic        underflow;
`ifdef UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int base;

  logic [7:0] p1;
  logic [7:0] p2;

  always #5 clk = ~clk;

  // Memory model: data for the address presented in cycle t appears in cycle t+2
  always @(posedge clk) begin
    p1 <= mem_addr[7:0];
    p2 <= p1;
    if (mem_rd) rd_cnt <= rd_cnt + 1;
  end
  assign mem_q = p2;

  fb_pixel_prefetch #(
    .ADDR_W     (24),
    .DATA_W     (8),
    .FIFO_DEPTH (16),
    .RD_LAT     (2),
    .FRAME_PIX  (FP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pix_en      (pix_en),
    .active      (active),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_q       (mem_q),
    .pix_data    (pix_data),
    .underflow   (underflow)
`ifdef UNDERFLOW_CNT_EN
    ,
    .underflow_cnt (underflow_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One strobe with active=1, then one idle cycle; checks the registered result
  task automatic pop_px(input string tag, input logic [3:0] exp, input logic exp_uf);
    pix_en = 1'b1;
    active = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    check({tag, " pix"}, 32'(pix_data), 32'(exp));
    check({tag, " uf"}, 32'(underflow), 32'(exp_uf));
    @(negedge clk);
  endtask

  task automatic start_frame(input string tag);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check({tag, " rd"}, 32'(mem_rd), 32'd1);
    check({tag, " addr"}, 32'(mem_addr), 32'd0);
    base = rd_cnt;
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; pix_en = 1'b0; active = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst addr", 32'(mem_addr), 32'd0);
    check("rst rd", 32'(mem_rd), 32'd0);
    check("rst pix", 32'(pix_data), 32'd0);
    check("rst uf", 32'(underflow), 32'd0);

    // Pop in IDLE: FIFO empty
    pop_px("idle_pop", 4'd0, 1'b1);
    check("uf pulse ends", 32'(underflow), 32'd0);

    // Frame 1: fill to 16 entries then stall
    start_frame("f1");
    repeat (30) @(negedge clk);
    check("fill rd count", 32'(rd_cnt - base), 32'd16);
    check("fill stall", 32'(mem_rd), 32'd0);
    check("fill addr", 32'(mem_addr), 32'd16);

    for (int k = 0; k < 1000; k++) pop_px("f1_stream", 4'(k), 1'b0);

    // Outside visible region: no pop, value held (999 -> 7)
    pix_en = 1'b1; active = 1'b0;
    @(negedge clk);
    pix_en = 1'b0;
    check("hold pix", 32'(pix_data), 32'd7);
    check("hold uf", 32'(underflow), 32'd0);

    // Frame 2 restart mid-frame, frame_start coinciding with a pop request
    pix_en = 1'b1; active = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("fs_pop pix", 32'(pix_data), 32'd7);
    check("fs_pop uf", 32'(underflow), 32'd0);
    check("fs rd", 32'(mem_rd), 32'd1);
    check("fs addr", 32'(mem_addr), 32'd0);
    base = rd_cnt;
    @(negedge clk);
    pix_en = 1'b0;
    check("flushed uf", 32'(underflow), 32'd1);
    check("flushed pix", 32'(pix_data), 32'd0);
    repeat (30) @(negedge clk);
    check("f2 fill count", 32'(rd_cnt - base), 32'd16);

    // Whole frame: stale returns must not appear in the sequence
    for (int k = 0; k < int'(FP); k++) pop_px("f2_stream", 4'(k), 1'b0);
    repeat (5) @(negedge clk);
    for (int k = 0; k < 20; k++) pop_px("drained", 4'd0, 1'b1);
    check("frame rd total", 32'(rd_cnt - base), 32'(FP));
    check("done rd", 32'(mem_rd), 32'd0);
`ifdef UNDERFLOW_CNT_EN
    check("uf cnt", 32'(underflow_cnt), 32'd22);
`endif

    // Frame 3, then reset while running with a strobe
    start_frame("f3");
    repeat (30) @(negedge clk);
    for (int k = 0; k < 6; k++) pop_px("f3_stream", 4'(k), 1'b0);
    rst = 1'b1; pix_en = 1'b1; active = 1'b1;
    @(negedge clk);
    rst = 1'b0; pix_en = 1'b0;
    check("mid rst addr", 32'(mem_addr), 32'd0);
    check("mid rst rd", 32'(mem_rd), 32'd0);
    check("mid rst pix", 32'(pix_data), 32'd0);
    check("mid rst uf", 32'(underflow), 32'd0);
`ifdef UNDERFLOW_CNT_EN
    check("mid rst cnt", 32'(underflow_cnt), 32'd0);
`endif
    base = rd_cnt;
    repeat (10) @(negedge clk);
    check("post rst no rd", 32'(rd_cnt - base), 32'd0);

    // Restart after reset: data from before reset is dropped
    start_frame("f4");
    repeat (30) @(negedge clk);
    for (int k = 0; k < 4; k++) pop_px("f4_stream", 4'(k), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
